// File: rtl/vermi_sequencer_if.sv
// Shared memory bus between the Vermicel sequencer (master) and memory (slave).
// A transfer completes on a cycle where mem_valid and mem_ready are both high.
interface vermi_sequencer_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_address;
    logic [3:0]  mem_wstrobe;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_address,
        output mem_wstrobe,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_address,
        input  mem_wstrobe,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/vermi_sequencer.sv
// Multi-cycle control sequencer and PC owner for the non-pipelined Vermicel core.
// Steps FETCH -> DECODE -> EXECUTE -> [LOAD | STORE] -> WRITEBACK and pulses commit in WRITEBACK.
// Optional feature: define VERMI_BUS_TIMEOUT_EN to abort any bus access that has waited
// TIMEOUT_CYCLES cycles; without it the sequencer waits forever and bus_error stays low.
module vermi_sequencer #(
    parameter logic [31:0] RESET_ADDRESS  = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    vermi_sequencer_if.master        bus,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic [31:0]              data_address,
    input  logic [3:0]               store_strobe,
    input  logic [31:0]              store_data,
    input  logic [31:0]              pc_next,
    output logic [31:0]              pc,
    output logic [31:0]              pc_incr,
    output logic [31:0]              instr_word,
    output logic [31:0]              load_data,
    output logic                     commit,
    output logic                     bus_error
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExecute,
        StLoad,
        StStore,
        StWriteback
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] load_q;
    logic        commit_q;
    logic        bus_error_q;
    logic        access;
    logic        abort;

    // The low PC bits are always forced to zero, so pc_next[1:0] is never consumed.
    logic unused_pc_next;
    assign unused_pc_next = ^pc_next[1:0];

    // Bus request, address mux and byte enables decode straight from the state register.
    assign access          = (state_q == StFetch) || (state_q == StLoad) || (state_q == StStore);
    assign bus.mem_valid   = access && !reset;
    assign bus.mem_address = (state_q == StFetch) ? pc_q : data_address;
    assign bus.mem_wstrobe = (state_q == StStore) ? store_strobe : 4'h0;
    assign bus.mem_wdata   = store_data;

`ifdef VERMI_BUS_TIMEOUT_EN
    // Abort on the last allowed stalled cycle, so mem_valid is high for exactly TIMEOUT_CYCLES
    // cycles; a mem_ready in that same cycle still wins.
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] wait_cnt_q;
    logic        waiting;

    assign waiting = bus.mem_valid && !bus.mem_ready;
    assign abort   = waiting && (wait_cnt_q == WAIT_LAST);

    // Count stalled cycles of the current access; any non-waiting cycle starts a fresh count.
    always_ff @(posedge clk) begin
        if (reset || !waiting || abort) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != WAIT_LAST) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign abort          = 1'b0;
`endif

    // Sequencer FSM owning the PC, fetched instruction, load data and the two pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StFetch;
            pc_q        <= RESET_ADDRESS;
            instr_q     <= NOP;
            load_q      <= '0;
            commit_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            commit_q    <= 1'b0;
            bus_error_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (bus.mem_ready) begin
                        instr_q <= bus.mem_rdata;
                        state_q <= StDecode;
                    end else if (abort) begin
                        instr_q     <= NOP;
                        bus_error_q <= 1'b1;
                        state_q     <= StDecode;
                    end
                end
                StDecode: begin
                    state_q <= StExecute;
                end
                StExecute: begin
                    // Load wins if decode ever flags both.
                    if (is_load) begin
                        state_q <= StLoad;
                    end else if (is_store) begin
                        state_q <= StStore;
                    end else begin
                        state_q  <= StWriteback;
                        commit_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (bus.mem_ready) begin
                        load_q   <= bus.mem_rdata;
                        state_q  <= StWriteback;
                        commit_q <= 1'b1;
                    end else if (abort) begin
                        load_q      <= '0;
                        bus_error_q <= 1'b1;
                        state_q     <= StWriteback;
                        commit_q    <= 1'b1;
                    end
                end
                StStore: begin
                    if (bus.mem_ready || abort) begin
                        bus_error_q <= abort && !bus.mem_ready;
                        state_q     <= StWriteback;
                        commit_q    <= 1'b1;
                    end
                end
                StWriteback: begin
                    pc_q    <= {pc_next[31:2], 2'b00};
                    state_q <= StFetch;
                end
                default: begin
                    state_q <= StFetch;
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign pc_incr    = pc_q + 32'd4;
    assign instr_word = instr_q;
    assign load_data  = load_q;
    assign commit     = commit_q;
    assign bus_error  = bus_error_q;

endmodule

// File: tb/tb_vermi_sequencer.sv
// Bench for vermi_sequencer: a memory responder with programmable wait states, a scoreboard
// of expected bus accesses, and per-instruction checks of commit timing, PC and data registers.
module tb_vermi_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0100;
    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int KAlu   = 0;
    localparam int KLoad  = 1;
    localparam int KStore = 2;
    localparam int KBoth  = 3;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic        is_wr;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        is_load, is_store;
    logic [31:0] data_address, store_data, pc_next;
    logic [3:0]  store_strobe;
    logic [31:0] pc, pc_incr, instr_word, load_data;
    logic        commit, bus_error;

    vermi_sequencer_if bus ();

    vermi_sequencer #(
        .RESET_ADDRESS  (RESET_ADDR),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .is_load      (is_load),
        .is_store     (is_store),
        .data_address (data_address),
        .store_strobe (store_strobe),
        .store_data   (store_data),
        .pc_next      (pc_next),
        .pc           (pc),
        .pc_incr      (pc_incr),
        .instr_word   (instr_word),
        .load_data    (load_data),
        .commit       (commit),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Responder configuration, written by the main thread.
    logic [31:0] cfg_daddr = 32'hFFFF_0000;
    logic [31:0] cfg_instr = NOP;
    logic [31:0] cfg_ldata = 32'h0;
    int          wait_fetch = 0;
    int          wait_data  = 0;
    logic        idle_ready = 1'b0;
    logic        ready_drv  = 1'b0;

    assign bus.mem_ready = ready_drv;
    assign bus.mem_rdata = (bus.mem_address == cfg_daddr) ? cfg_ldata : cfg_instr;

    acc_t exp_q[$];

    // Responder and scoreboard: decide mem_ready mid-cycle, pop and compare on acceptance,
    // and check that a stalled request holds its address, strobe and data.
    int          vcycles = 0;
    logic        held = 1'b0;
    logic [31:0] held_addr, held_wdata;
    logic [3:0]  held_strb;
    always @(negedge clk) begin
        acc_t e;
        int   wait_cur;
        if (bus.mem_valid) begin
            if (held) begin
                check("hold_addr", bus.mem_address, held_addr);
                check("hold_strb", 32'(bus.mem_wstrobe), 32'(held_strb));
                check("hold_wdata", bus.mem_wdata, held_wdata);
            end
            vcycles++;
            wait_cur  = (bus.mem_address == cfg_daddr) ? wait_data : wait_fetch;
            ready_drv = (vcycles > wait_cur);
            if (ready_drv) begin
                check("access_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("acc_addr", bus.mem_address, e.addr);
                    check("acc_strb", 32'(bus.mem_wstrobe), 32'(e.strb));
                    if (e.is_wr) check("acc_wdata", bus.mem_wdata, e.wdata);
                end
                held    = 1'b0;
                vcycles = 0;
            end else begin
                held       = 1'b1;
                held_addr  = bus.mem_address;
                held_strb  = bus.mem_wstrobe;
                held_wdata = bus.mem_wdata;
            end
        end else begin
            ready_drv = idle_ready;
            held      = 1'b0;
            vcycles   = 0;
        end
    end

    // Reference state carried across instructions.
    logic [31:0] pc_model, ld_model;
    logic [31:0] cur_instr, cur_pcn;
    int          cur_exp_cycles;

    // Called at the start of a FETCH cycle: drive decode/ALU inputs and queue expected accesses.
    task automatic setup(input int kind, input logic [31:0] instr, input logic [31:0] pcn,
                         input logic [31:0] daddr, input logic [3:0] strb,
                         input logic [31:0] sdata, input logic [31:0] ldata,
                         input int wf, input int wd, input bit push);
        logic ld, st;
        ld = (kind == KLoad) || (kind == KBoth);
        st = (kind == KStore) || (kind == KBoth);
        is_load      = ld;
        is_store     = st;
        pc_next      = pcn;
        data_address = daddr;
        store_strobe = strb;
        store_data   = sdata;
        cfg_daddr    = daddr;
        cfg_instr    = instr;
        cfg_ldata    = ldata;
        wait_fetch   = wf;
        wait_data    = wd;
        cur_instr    = instr;
        cur_pcn      = pcn;
        cur_exp_cycles = 4 + wf + ((ld || st) ? 1 + wd : 0);
        if (push) begin
            exp_q.push_back('{addr: pc_model, strb: 4'h0, wdata: 32'h0, is_wr: 1'b0});
            if (ld) begin
                exp_q.push_back('{addr: daddr, strb: 4'h0, wdata: 32'h0, is_wr: 1'b0});
                ld_model = ldata;
            end else if (st) begin
                exp_q.push_back('{addr: daddr, strb: strb, wdata: sdata, is_wr: 1'b1});
            end
        end
    endtask

    // Run one instruction from its FETCH cycle through commit; returns in the next FETCH cycle.
    task automatic do_instr(input int kind, input logic [31:0] instr, input logic [31:0] pcn,
                            input logic [31:0] daddr, input logic [3:0] strb,
                            input logic [31:0] sdata, input logic [31:0] ldata,
                            input int wf, input int wd);
        int n;
        check("pc", pc, pc_model);
        check("pc_incr", pc_incr, pc_model + 32'd4);
        setup(kind, instr, pcn, daddr, strb, sdata, ldata, wf, wd, 1'b1);
        n = 1;
        while (commit !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("commit_cycle", 32'(n), 32'(cur_exp_cycles));
        check("instr_word", instr_word, cur_instr);
        check("load_data", load_data, ld_model);
        check("no_bus_error", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        check("commit_one_cycle", 32'(commit), 32'd0);
        pc_model = {cur_pcn[31:2], 2'b00};
    endtask

    initial begin
        int n;
        is_load      = 1'b0;
        is_store     = 1'b0;
        data_address = 32'h0;
        store_strobe = 4'h0;
        store_data   = 32'h0;
        pc_next      = 32'h0;
        pc_model     = RESET_ADDR;
        ld_model     = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", pc, RESET_ADDR);
        check("rst_instr", instr_word, NOP);
        check("rst_load", load_data, 32'h0);
        check("rst_commit", 32'(commit), 32'd0);
        check("rst_bus_error", 32'(bus_error), 32'd0);
        check("rst_valid", 32'(bus.mem_valid), 32'd0);
        reset = 1'b0;

        // ALU, zero-wait: commit on cycle 4, next fetch at 0x104.
        do_instr(KAlu, 32'h00A0_0093, 32'h0000_0104, 32'hFFFF_0000, 4'h0, 32'h0, 32'h0, 0, 0);
        // Load, zero-wait: commit on cycle 5.
        do_instr(KLoad, 32'h0000_2083, 32'h0000_0108, 32'h0000_2000, 4'h0, 32'h0,
                 32'hDEAD_BEEF, 0, 0);
        // Store held over 3 wait cycles; ready while idle must be ignored; pc_next LSBs cleared.
        idle_ready = 1'b1;
        do_instr(KStore, 32'h0010_9023, 32'h0000_0207, 32'h0000_2004, 4'b0011, 32'h0000_ABCD,
                 32'h0, 0, 3);
        // ALU with a stalled fetch, jumping to the top of the address space.
        do_instr(KAlu, 32'h0000_0033, 32'hFFFF_FFFC, 32'hFFFF_0000, 4'h0, 32'h0, 32'h0, 2, 0);
        check("pc_incr_wrap", pc_incr, 32'h0);
        // Both load and store flagged: load path, no write strobes.
        do_instr(KBoth, 32'h0000_2103, 32'h0000_0000, 32'h0000_0040, 4'hF, 32'h5555_5555,
                 32'h1234_5678, 0, 2);
        // Store at pc 0 with one wait on each access.
        do_instr(KStore, 32'h0020_2223, 32'h0000_0010, 32'h0000_0044, 4'b1100, 32'hBEEF_0000,
                 32'h0, 1, 1);

`ifdef VERMI_BUS_TIMEOUT_EN
        // Fetch never answered: abort after 8 request cycles, NOP decoded, commit 2 cycles later.
        setup(KAlu, 32'hCAFE_0093, 32'h0000_0014, 32'hFFFF_0000, 4'h0, 32'h0, 32'h0,
              1000, 0, 1'b0);
        n = 1;
        while (bus_error !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycle", 32'(n), 32'd9);
        check("timeout_valid_drop", 32'(bus.mem_valid), 32'd0);
        check("timeout_instr_nop", instr_word, NOP);
        n = 0;
        while (commit !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_commit_gap", 32'(n), 32'd2);
        check("timeout_error_pulse", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        pc_model = 32'h0000_0014;
`endif

        // Reset during a stalled load: access abandoned, no commit, restart at RESET_ADDR.
        setup(KLoad, 32'h0000_3083, 32'h0000_0018, 32'h0000_3000, 4'h0, 32'h0, 32'h0BAD_0BAD,
              0, 1000, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            check("stall_no_commit", 32'(commit), 32'd0);
        end
        check("stall_valid", 32'(bus.mem_valid), 32'd1);
        check("stall_addr", bus.mem_address, 32'h0000_3000);
        reset = 1'b1;
        #1;
        check("reset_forces_valid", 32'(bus.mem_valid), 32'd0);
        @(posedge clk); #1;
        check("reset_pc", pc, RESET_ADDR);
        check("reset_commit", 32'(commit), 32'd0);
        check("reset_load", load_data, 32'h0);
        check("reset_instr", instr_word, NOP);
        check("pending_load_entry", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        pc_model = RESET_ADDR;
        ld_model = 32'h0;
        reset = 1'b0;
        #1;
        check("refetch_valid", 32'(bus.mem_valid), 32'd1);
        check("refetch_addr", bus.mem_address, RESET_ADDR);
        do_instr(KAlu, 32'h0010_0093, 32'h0000_0104, 32'hFFFF_0000, 4'h0, 32'h0, 32'h0, 0, 0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
